// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
package mips_pkg;
  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] fwd_t;

  localparam fwd_t     FWD_RF   = 2'b00;
  localparam fwd_t     FWD_WB   = 2'b01;
  localparam fwd_t     FWD_MEM  = 2'b10;
  localparam reg_idx_t REG_ZERO = 5'd0;

  typedef struct packed {
    reg_idx_t rs;
    reg_idx_t rt;
    reg_idx_t dst;
    logic     regwrite;
    logic     memtoreg;
  } ex_stage_t;

  typedef struct packed {
    reg_idx_t dst;
    logic     regwrite;
    logic     memtoreg;
  } mem_stage_t;

  typedef struct packed {
    reg_idx_t dst;
    logic     regwrite;
  } wb_stage_t;
endpackage

// File: rtl/forward_hazard_unit_if.sv
// ID-stage decode in, forwarding/stall controls out.
interface forward_hazard_unit_if import mips_pkg::*; #(parameter int STALL_CNT_W = 16);
  reg_idx_t               rs_D;
  reg_idx_t               rt_D;
  reg_idx_t               dst_D;
  logic                   regwrite_D;
  logic                   memtoreg_D;
  logic                   flush_in;
  fwd_t                   Forward_RSE;
  fwd_t                   Forward_RTE;
  logic                   stall_F;
  logic                   stall_D;
  logic                   flush_E;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output rs_D, rt_D, dst_D, regwrite_D, memtoreg_D, flush_in,
    input  Forward_RSE, Forward_RTE, stall_F, stall_D, flush_E, stall_count
  );

  modport slave (
    input  rs_D, rt_D, dst_D, regwrite_D, memtoreg_D, flush_in,
    output Forward_RSE, Forward_RTE, stall_F, stall_D, flush_E, stall_count
  );
endinterface

// File: rtl/fwd_select.sv
// Forward source select for one EX operand; MEM beats WB, $zero never forwards.
module fwd_select import mips_pkg::*; (
  input  reg_idx_t src,
  input  reg_idx_t dst_m,
  input  logic     regwrite_m,
  input  logic     memtoreg_m,
  input  reg_idx_t dst_w,
  input  logic     regwrite_w,
  output fwd_t     fwd
);
  always_comb begin
    fwd = FWD_RF;
    // A load in MEM has no data yet; the load-use stall delays the consumer to meet it in WB.
    if (src != REG_ZERO && regwrite_m && !memtoreg_m && dst_m == src)
      fwd = FWD_MEM;
    else if (src != REG_ZERO && regwrite_w && dst_w == src)
      fwd = FWD_WB;
  end
endmodule

// File: rtl/forward_hazard_unit.sv
// Shadow EX/MEM/WB tracking, operand forward selects and load-use stall generation.
module forward_hazard_unit import mips_pkg::*; #(
  parameter int STALL_CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  forward_hazard_unit_if.slave hz
);
  ex_stage_t              e;
  mem_stage_t             m;
  wb_stage_t              w;
  logic [STALL_CNT_W-1:0] cnt;
  logic                   lwstall;
  logic                   flush_e;
  reg_idx_t [1:0]         src;
  fwd_t     [1:0]         fwd;

  assign src = {e.rt, e.rs};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_op
      fwd_select u_sel (
        .src        (src[g]),
        .dst_m      (m.dst),
        .regwrite_m (m.regwrite),
        .memtoreg_m (m.memtoreg),
        .dst_w      (w.dst),
        .regwrite_w (w.regwrite),
        .fwd        (fwd[g])
      );
    end
  endgenerate

  assign lwstall = e.memtoreg && e.regwrite && e.dst != REG_ZERO &&
                   (e.dst == hz.rs_D || e.dst == hz.rt_D);
  assign flush_e = lwstall || hz.flush_in;

  assign hz.Forward_RSE = fwd[0];
  assign hz.Forward_RTE = fwd[1];
  assign hz.stall_F     = lwstall;
  assign hz.stall_D     = lwstall;
  assign hz.flush_E     = flush_e;
  assign hz.stall_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      e   <= '0;
      m   <= '0;
      w   <= '0;
      cnt <= '0;
    end else begin
      w <= '{dst: m.dst, regwrite: m.regwrite};
      m <= '{dst: e.dst, regwrite: e.regwrite, memtoreg: e.memtoreg};
      if (flush_e) e <= '0;
      else         e <= '{rs: hz.rs_D, rt: hz.rt_D, dst: hz.dst_D,
                          regwrite: hz.regwrite_D, memtoreg: hz.memtoreg_D};
      if (lwstall && cnt != '1) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed instruction table, reset corner sequences and a random run against a pipeline model.
module tb_forward_hazard_unit;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  forward_hazard_unit_if #(.STALL_CNT_W(16)) hz ();
  forward_hazard_unit #(.STALL_CNT_W(16)) dut (.clk(clk), .rst(rst), .hz(hz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt, dst;
    logic       wr, ld, fl;
    logic [1:0] ers, ert;
    logic       est, efl;
    int         ecnt;
  } vec_t;

  typedef struct {
    int rs, rt, dst;
    bit wr, ld;
  } ins_t;

  ins_t pipe[$];  // [0]=EX, [1]=MEM, [2]=WB, instructions in flight
  int   mdl_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int dst, input bit wr, input bit ld,
                       input bit fl);
    hz.rs_D = 5'(rs); hz.rt_D = 5'(rt); hz.dst_D = 5'(dst);
    hz.regwrite_D = wr; hz.memtoreg_D = ld; hz.flush_in = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an older instruction supplies src if it writes it; youngest wins,
  // except a load still one step ahead, whose data is not yet available.
  function automatic int mdl_fwd(input int src);
    if (src == 0) return 0;
    for (int age = 1; age <= 2; age++)
      if (pipe[age].wr && pipe[age].dst == src && !(age == 1 && pipe[age].ld))
        return (age == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic bit mdl_lw(input int rs, input int rt);
    return pipe[0].ld && pipe[0].wr && pipe[0].dst != 0 &&
           (pipe[0].dst == rs || pipe[0].dst == rt);
  endfunction

  task automatic mdl_reset();
    ins_t b;
    b = '{0, 0, 0, 1'b0, 1'b0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(b);
    mdl_cnt = 0;
  endtask

  vec_t tbl[27];

  initial begin
    ins_t id, bub;
    bit   st, fe;
    bub = '{0, 0, 0, 1'b0, 1'b0};

    //        rs  rt dst wr ld fl   ers  ert  st fe cnt
    tbl[0]  = '{1, 2, 3, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // add $3
    tbl[1]  = '{3, 1, 4, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // sub $4,$3,$1
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 0, 0, 0};  // sub in EX: rs from MEM
    tbl[3]  = '{1, 2, 3, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // add $3
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // nop
    tbl[5]  = '{2, 3, 5, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // or $5,$2,$3
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 0};  // or in EX: rt from WB
    tbl[7]  = '{1, 7, 7, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // addi $7,$1
    tbl[8]  = '{7, 7, 7, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0};  // addi $7,$7
    tbl[9]  = '{7, 7, 8, 1, 0, 0, 2'd2, 2'd2, 0, 0, 0};  // add $8,$7,$7
    tbl[10] = '{0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 0, 0, 0};  // both match, MEM wins
    tbl[11] = '{1, 5, 5, 1, 1, 0, 2'd0, 2'd0, 0, 0, 0};  // lw $5
    tbl[12] = '{1, 5, 6, 1, 0, 0, 2'd0, 2'd0, 1, 1, 0};  // add $6,$1,$5 -> stall
    tbl[13] = '{1, 5, 6, 1, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // held, no stall
    tbl[14] = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 0, 0, 1};  // consumer meets load in WB
    tbl[15] = '{0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // addi $0,$0,9
    tbl[16] = '{0, 0, 2, 1, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // add $2,$0,$0
    tbl[17] = '{1, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 0, 1};  // lw $0
    tbl[18] = '{0, 0, 3, 1, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // use $0: no stall
    tbl[19] = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1};
    tbl[20] = '{1, 2, 3, 1, 0, 1, 2'd0, 2'd0, 0, 1, 1};  // add $3 flushed
    tbl[21] = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1};
    tbl[22] = '{3, 3, 4, 1, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // or $4,$3,$3
    tbl[23] = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1};  // $3 producer was a bubble
    tbl[24] = '{1, 5, 5, 1, 1, 0, 2'd0, 2'd0, 0, 0, 1};  // lw $5
    tbl[25] = '{5, 5, 6, 1, 0, 1, 2'd0, 2'd0, 1, 1, 1};  // stall + flush_in together
    tbl[26] = '{0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 2};

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("reset_rse", hz.Forward_RSE, 0);
    chk("reset_rte", hz.Forward_RTE, 0);
    chk("reset_stall_f", hz.stall_F, 0);
    chk("reset_stall_d", hz.stall_D, 0);
    chk("reset_cnt", int'(hz.stall_count), 0);
    drive(0, 0, 0, 0, 0, 1);
    #1 chk("reset_flush_follows_in", hz.flush_E, 1);
    drive(0, 0, 0, 0, 0, 0);
    #1 chk("reset_flush_idle", hz.flush_E, 0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].dst, tbl[i].wr, tbl[i].ld, tbl[i].fl);
      #2;
      chk($sformatf("tbl%0d_rse", i), hz.Forward_RSE, tbl[i].ers);
      chk($sformatf("tbl%0d_rte", i), hz.Forward_RTE, tbl[i].ert);
      chk($sformatf("tbl%0d_stall_f", i), hz.stall_F, tbl[i].est);
      chk($sformatf("tbl%0d_stall_d", i), hz.stall_D, tbl[i].est);
      chk($sformatf("tbl%0d_flush_e", i), hz.flush_E, tbl[i].efl);
      chk($sformatf("tbl%0d_cnt", i), int'(hz.stall_count), tbl[i].ecnt);
      tick();
    end

    // Reset during a load-use stall: in-flight producers must be forgotten
    drive(1, 2, 3, 1, 0, 0); tick();   // add $3
    drive(1, 5, 5, 1, 1, 0); tick();   // lw $5
    drive(3, 5, 6, 1, 0, 0);           // add $6,$3,$5
    #2 chk("midstall_stall_seen", hz.stall_F, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midstall_stall_f", hz.stall_F, 0);
    chk("midstall_flush_e", hz.flush_E, 0);
    chk("midstall_cnt", int'(hz.stall_count), 0);
    chk("midstall_rse", hz.Forward_RSE, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    chk("midstall_stale_rse", hz.Forward_RSE, 0);
    chk("midstall_stale_rte", hz.Forward_RTE, 0);
    tick();

    // Random run against the pipeline model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mdl_reset();
    for (int n = 0; n < 400; n++) begin
      bit r;
      id.rs  = $urandom_range(0, 7);
      id.rt  = $urandom_range(0, 7);
      id.dst = $urandom_range(0, 7);
      id.wr  = $urandom_range(0, 3) != 0;
      id.ld  = $urandom_range(0, 2) == 0;
      r      = $urandom_range(0, 49) == 0;
      drive(id.rs, id.rt, id.dst, id.wr, id.ld, $urandom_range(0, 7) == 0);
      rst = r;
      #2;
      st = mdl_lw(id.rs, id.rt);
      fe = st || hz.flush_in;
      chk("rnd_rse", hz.Forward_RSE, mdl_fwd(pipe[0].rs));
      chk("rnd_rte", hz.Forward_RTE, mdl_fwd(pipe[0].rt));
      chk("rnd_stall_f", hz.stall_F, st);
      chk("rnd_stall_d", hz.stall_D, st);
      chk("rnd_flush_e", hz.flush_E, fe);
      chk("rnd_cnt", int'(hz.stall_count), mdl_cnt);
      tick();
      if (r) mdl_reset();
      else begin
        if (st && mdl_cnt < 65535) mdl_cnt++;
        void'(pipe.pop_back());
        pipe.push_front(fe ? bub : id);
      end
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
